// File: rtl/dunc16_pkg.sv
// ---------------------------------------------------------------------------
// dunc16_pkg
// Shared constants for the dunc16 control sequencer:
//   - opcode values carried in IR_OUT
//   - phase and T-state encodings used by the timing generator
//   - mux select values for the PC, MA, MD and AC input muxes
//   - the packed {phase, tstate} state record
// No ports (package).
// ---------------------------------------------------------------------------
package dunc16_pkg;

  // Opcodes; every value not listed here executes as a NOP.
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_BAN = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Instruction phase.
  localparam logic PH_FETCH   = 1'b0;
  localparam logic PH_EXECUTE = 1'b1;

  // T-state, stored binary and expanded to one-hot at the outputs.
  localparam logic [1:0] TS_T0 = 2'd0;
  localparam logic [1:0] TS_T1 = 2'd1;
  localparam logic [1:0] TS_T2 = 2'd2;
  localparam logic [1:0] TS_T3 = 2'd3;

  // PC_SEL values.
  localparam logic SEL_PC_INC = 1'b0;
  localparam logic SEL_PC_JMP = 1'b1;

  // MA_SEL values.
  localparam logic SEL_PC = 1'b0;
  localparam logic SEL_MD = 1'b1;

  // MD_SEL values.
  localparam logic SEL_MEM = 1'b0;
  localparam logic SEL_AC  = 1'b1;

  // AC_SEL values.
  localparam logic AC_MD  = 1'b0;
  localparam logic AC_SUM = 1'b1;

  typedef struct packed {
    logic       phase;
    logic [1:0] tstate;
  } ctrl_state_t;

  localparam ctrl_state_t RESET_STATE = '{phase: PH_FETCH, tstate: TS_T0};

  // Opcodes whose EXECUTE T0 issues a memory read of the operand.
  function automatic logic op_reads_mem(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/dunc16_ctrl_if.sv
// ---------------------------------------------------------------------------
// dunc16_ctrl_if
// Memory handshake between the dunc16 control sequencer and the memory.
//   MEM_REQ  controller -> memory  access request
//   MEM_WE   controller -> memory  1 = write, 0 = read
//   MEM_ACK  memory -> controller  access completes this cycle
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface dunc16_ctrl_if;
  logic MEM_REQ;
  logic MEM_WE;
  logic MEM_ACK;

  modport master (output MEM_REQ, output MEM_WE, input MEM_ACK);
  modport slave  (input MEM_REQ, input MEM_WE, output MEM_ACK);
endinterface

// File: rtl/dunc16_tgen.sv
// ---------------------------------------------------------------------------
// dunc16_tgen
// Timing generator: {phase, tstate} register, stall counter, timeout flag.
//   CLK      in   system clock
//   RESET    in   synchronous active-high reset
//   hold     in   keep the current T-state this cycle
//   stall    in   a memory request is outstanding without ACK this cycle
//   state    out  current {phase, tstate}
//   timeout  out  this stall cycle is the WAIT_LIMIT-th without ACK
// ---------------------------------------------------------------------------
module dunc16_tgen
  import dunc16_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_W     = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        hold,
  input  logic        stall,
  output ctrl_state_t state,
  output logic        timeout
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_LIMIT - 1);

  logic [WAIT_W-1:0] stall_cnt;

  // The counter holds the number of stall cycles already completed, so the
  // limit is hit during the cycle that would make it WAIT_LIMIT. An ACK in
  // that cycle means it is not a stall, so the access wins over the error.
  assign timeout = stall && (stall_cnt == LAST_WAIT);

  // T-state advances unless held; T3 wraps to T0 and flips the phase.
  // The stall counter clears on every advance and whenever no stall is
  // pending, and stops at the limit because the controller halts then.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= RESET_STATE;
      stall_cnt <= '0;
    end else if (!hold) begin
      state.tstate <= state.tstate + 2'd1;
      if (state.tstate == TS_T3) begin
        state.phase <= ~state.phase;
      end
      stall_cnt <= '0;
    end else if (stall && !timeout) begin
      stall_cnt <= stall_cnt + WAIT_W'(1);
    end else if (!stall) begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: rtl/dunc16_ctrl.sv
// ---------------------------------------------------------------------------
// dunc16_ctrl
// Control sequencer for the dunc16 16-bit accumulator datapath.
//   CLK, RESET           clock, synchronous active-high reset
//   mem                  memory handshake (MEM_REQ, MEM_WE, MEM_ACK)
//   IR_OUT               opcode from the datapath IR
//   AZ, AN               AC == 0, AC negative (AZ currently unused)
//   T0..T3               one-hot timing state
//   FETCH, EXECUTE       phase flags
//   EN_PC..EN_IR         register load enables
//   PC_SEL..AC_SEL       datapath mux selects
//   I_LDA..I_HLT         combinational opcode decodes
//   HALTED, BUS_ERR      sticky status, cleared only by RESET
// ---------------------------------------------------------------------------
module dunc16_ctrl
  import dunc16_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  dunc16_ctrl_if.master    mem,
  input  logic [3:0]       IR_OUT,
  input  logic             AZ,
  input  logic             AN,
  output logic             T0,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             FETCH,
  output logic             EXECUTE,
  output logic             EN_PC,
  output logic             EN_MA,
  output logic             EN_MD,
  output logic             EN_AC,
  output logic             EN_IR,
  output logic             PC_SEL,
  output logic             MA_SEL,
  output logic             MD_SEL,
  output logic             AC_SEL,
  output logic             I_LDA,
  output logic             I_STA,
  output logic             I_ADD,
  output logic             I_JMP,
  output logic             I_BAN,
  output logic             I_HLT,
  output logic             HALTED,
  output logic             BUS_ERR
);

  ctrl_state_t state;
  logic        timeout;
  logic        stall;
  logic        hold;
  logic        active;
  logic        halt_now;
  logic        halted;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic        unused_inputs;

  // AZ is reserved for a future branch-on-zero opcode.
  assign unused_inputs = AZ;

  assign I_LDA = (IR_OUT == OP_LDA);
  assign I_STA = (IR_OUT == OP_STA);
  assign I_ADD = (IR_OUT == OP_ADD);
  assign I_JMP = (IR_OUT == OP_JMP);
  assign I_BAN = (IR_OUT == OP_BAN);
  assign I_HLT = (IR_OUT == OP_HLT);

  assign FETCH   = (state.phase == PH_FETCH);
  assign EXECUTE = (state.phase == PH_EXECUTE);
  assign T0      = (state.tstate == TS_T0);
  assign T1      = (state.tstate == TS_T1);
  assign T2      = (state.tstate == TS_T2);
  assign T3      = (state.tstate == TS_T3);

  // Reset and halt both silence every enable and memory strobe at once,
  // so an aborted write never sees an enable after the reset edge.
  assign active   = !RESET && !halted;
  assign halt_now = active && EXECUTE && T0 && I_HLT;
  assign stall    = mem_req && !mem.MEM_ACK;
  assign hold     = halted || stall || halt_now;

  assign mem.MEM_REQ = mem_req;
  assign mem.MEM_WE  = mem_we;
  assign HALTED      = halted;
  assign BUS_ERR     = bus_err;

  dunc16_tgen #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WAIT_W     (WAIT_W)
  ) u_tgen (
    .CLK     (CLK),
    .RESET   (RESET),
    .hold    (hold),
    .stall   (stall),
    .state   (state),
    .timeout (timeout)
  );

  // Enable/select/strobe decode from {phase, tstate, opcode}. Enables that
  // capture memory data are qualified with MEM_ACK, which only matters
  // inside request states, so a stray ACK elsewhere has no effect.
  always_comb begin
    EN_PC   = 1'b0;
    EN_MA   = 1'b0;
    EN_MD   = 1'b0;
    EN_AC   = 1'b0;
    EN_IR   = 1'b0;
    PC_SEL  = SEL_PC_INC;
    MA_SEL  = SEL_PC;
    MD_SEL  = SEL_MEM;
    AC_SEL  = AC_MD;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    if (active) begin
      if (FETCH) begin
        case (state.tstate)
          TS_T0: begin
            EN_MA  = 1'b1;
            MA_SEL = SEL_PC;
          end
          TS_T1: begin
            mem_req = 1'b1;
            if (mem.MEM_ACK) begin
              EN_MD  = 1'b1;
              MD_SEL = SEL_MEM;
              EN_PC  = 1'b1;
              PC_SEL = SEL_PC_INC;
            end
          end
          TS_T2: begin
            EN_IR  = 1'b1;
            EN_MA  = 1'b1;
            MA_SEL = SEL_MD;
          end
          default: ;
        endcase
      end else begin
        case (state.tstate)
          TS_T0: begin
            if (op_reads_mem(IR_OUT)) begin
              mem_req = 1'b1;
              if (mem.MEM_ACK) begin
                EN_MD  = 1'b1;
                MD_SEL = SEL_MEM;
              end
            end else if (I_STA) begin
              EN_MD  = 1'b1;
              MD_SEL = SEL_AC;
            end else if (I_JMP || (I_BAN && AN)) begin
              EN_PC  = 1'b1;
              PC_SEL = SEL_PC_JMP;
            end
          end
          TS_T1: begin
            if (I_LDA) begin
              EN_AC  = 1'b1;
              AC_SEL = AC_MD;
            end else if (I_ADD) begin
              EN_AC  = 1'b1;
              AC_SEL = AC_SUM;
            end else if (I_STA) begin
              mem_req = 1'b1;
              mem_we  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky status: a bus timeout sets both flags, HLT sets only HALTED.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (timeout) begin
        halted  <= 1'b1;
        bus_err <= 1'b1;
      end
      if (halt_now) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dunc16_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dunc16_ctrl
// Directed self-checking bench for dunc16_ctrl, built with WAIT_LIMIT=4 so
// the bus timeout is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_dunc16_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] ir_out;
  logic       az_in;
  logic       an_in;
  logic t0, t1, t2, t3, fetch, execute;
  logic en_pc, en_ma, en_md, en_ac, en_ir;
  logic pc_sel, ma_sel, md_sel, ac_sel;
  logic i_lda, i_sta, i_add, i_jmp, i_ban, i_hlt;
  logic halted, bus_err;

  logic [5:0] st_vec;
  logic [4:0] en_vec;
  logic [5:0] dec_vec;

  int test_count;
  int fail_count;

  int         en_pc_count;
  logic [4:0] e0_en;
  logic [4:0] e1_en;
  logic       e0_md_sel;
  logic       e1_ac_sel;
  logic       last_pc_sel;
  int         e1_cycles;
  int         e1_wr_cycles;
  int         activity;

  localparam logic [5:0] ST_FT0 = 6'b10_1000;
  localparam logic [5:0] ST_FT1 = 6'b10_0100;
  localparam logic [5:0] ST_ET0 = 6'b01_1000;
  localparam logic [5:0] ST_ET1 = 6'b01_0100;

  dunc16_ctrl_if mem_bus ();

  dunc16_ctrl #(
    .WAIT_LIMIT (4),
    .WAIT_W     (3)
  ) dut (
    .CLK     (clk),
    .RESET   (reset),
    .mem     (mem_bus),
    .IR_OUT  (ir_out),
    .AZ      (az_in),
    .AN      (an_in),
    .T0      (t0),
    .T1      (t1),
    .T2      (t2),
    .T3      (t3),
    .FETCH   (fetch),
    .EXECUTE (execute),
    .EN_PC   (en_pc),
    .EN_MA   (en_ma),
    .EN_MD   (en_md),
    .EN_AC   (en_ac),
    .EN_IR   (en_ir),
    .PC_SEL  (pc_sel),
    .MA_SEL  (ma_sel),
    .MD_SEL  (md_sel),
    .AC_SEL  (ac_sel),
    .I_LDA   (i_lda),
    .I_STA   (i_sta),
    .I_ADD   (i_add),
    .I_JMP   (i_jmp),
    .I_BAN   (i_ban),
    .I_HLT   (i_hlt),
    .HALTED  (halted),
    .BUS_ERR (bus_err)
  );

  assign st_vec  = {fetch, execute, t0, t1, t2, t3};
  assign en_vec  = {en_pc, en_ma, en_md, en_ac, en_ir};
  assign dec_vec = {i_lda, i_sta, i_add, i_jmp, i_ban, i_hlt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop in case the sequencer never returns to a checkable state.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ir, input logic an,
                               input logic ack);
    ir_out          = ir;
    an_in           = an;
    mem_bus.MEM_ACK = ack;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
  endtask

  // Runs one instruction from FETCH T0 back to FETCH T0. The memory model
  // acknowledges a read after rd_delay wait cycles and a write after
  // wr_delay wait cycles.
  task automatic runInstr(input string tag, input logic [3:0] ir,
                          input logic an, input int rd_delay,
                          input int wr_delay, input int exp_clocks);
    int clocks;
    int wait_cnt;
    clocks       = 0;
    wait_cnt     = 0;
    en_pc_count  = 0;
    e0_en        = '0;
    e1_en        = '0;
    e0_md_sel    = 1'b0;
    e1_ac_sel    = 1'b0;
    last_pc_sel  = 1'b0;
    e1_cycles    = 0;
    e1_wr_cycles = 0;
    ir_out       = ir;
    an_in        = an;
    do begin
      mem_bus.MEM_ACK = 1'b0;
      #1;
      if (mem_bus.MEM_REQ) begin
        if (wait_cnt >= (mem_bus.MEM_WE ? wr_delay : rd_delay)) begin
          mem_bus.MEM_ACK = 1'b1;
          wait_cnt        = 0;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (en_pc) begin
        en_pc_count++;
        last_pc_sel = pc_sel;
      end
      if (execute && t0) begin
        e0_en     = en_vec;
        e0_md_sel = md_sel;
      end
      if (execute && t1) begin
        e1_cycles++;
        e1_en     = en_vec;
        e1_ac_sel = ac_sel;
        if (mem_bus.MEM_REQ && mem_bus.MEM_WE) e1_wr_cycles++;
      end
      clocks++;
      nextCycle();
    end while (!(fetch && t0) && clocks < 40);
    checkOutput({tag, " clocks"}, clocks, exp_clocks);
  endtask

  initial begin
    logic [3:0] dec_ops [7];
    logic [5:0] dec_exp [7];
    dec_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h7};
    dec_exp = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
                6'b000010, 6'b000001, 6'b000000};

    test_count      = 0;
    fail_count      = 0;
    reset           = 1'b1;
    az_in           = 1'b0;
    an_in           = 1'b0;
    ir_out          = 4'h0;
    mem_bus.MEM_ACK = 1'b0;

    // Reset held for two clocks, then released.
    repeat (2) nextCycle();
    checkOutput("reset state", st_vec, ST_FT0);
    checkOutput("reset enables", en_vec, 5'b00000);
    checkOutput("reset mem_req", mem_bus.MEM_REQ, 1'b0);
    checkOutput("reset halted", halted, 1'b0);
    checkOutput("reset bus_err", bus_err, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("first en_ma", en_ma, 1'b1);
    checkOutput("first ma_sel", ma_sel, 1'b0);

    // Zero-wait LDA.
    runInstr("lda", 4'h0, 1'b0, 0, 0, 8);
    checkOutput("lda en_pc count", en_pc_count, 1);
    checkOutput("lda exec t0 en", e0_en, 5'b00100);
    checkOutput("lda exec t1 en", e1_en, 5'b00010);
    checkOutput("lda ac_sel", e1_ac_sel, 1'b0);

    // Zero-wait ADD.
    runInstr("add", 4'h2, 1'b0, 0, 0, 8);
    checkOutput("add exec t1 en", e1_en, 5'b00010);
    checkOutput("add ac_sel", e1_ac_sel, 1'b1);

    // LDA with three read waits: ACK lands in the cycle the limit would hit.
    runInstr("lda slow", 4'h0, 1'b0, 3, 0, 14);
    checkOutput("lda slow bus_err", bus_err, 1'b0);
    checkOutput("lda slow halted", halted, 1'b0);

    // STA with the write acknowledged after three waits.
    runInstr("sta", 4'h1, 1'b0, 0, 3, 11);
    checkOutput("sta exec t1 cycles", e1_cycles, 4);
    checkOutput("sta write cycles", e1_wr_cycles, 4);
    checkOutput("sta exec t0 en", e0_en, 5'b00100);
    checkOutput("sta md_sel", e0_md_sel, 1'b1);

    // JMP and BAN.
    runInstr("jmp", 4'h3, 1'b0, 0, 0, 8);
    checkOutput("jmp en_pc count", en_pc_count, 2);
    checkOutput("jmp exec t0 en", e0_en, 5'b10000);
    checkOutput("jmp pc_sel", last_pc_sel, 1'b1);
    runInstr("ban taken", 4'h4, 1'b1, 0, 0, 8);
    checkOutput("ban taken en_pc count", en_pc_count, 2);
    checkOutput("ban taken exec t0 en", e0_en, 5'b10000);
    checkOutput("ban taken pc_sel", last_pc_sel, 1'b1);
    runInstr("ban not taken", 4'h4, 1'b0, 0, 0, 8);
    checkOutput("ban not taken en_pc count", en_pc_count, 1);
    checkOutput("ban not taken exec t0 en", e0_en, 5'b00000);

    // Unused opcode behaves as NOP.
    runInstr("nop", 4'h7, 1'b0, 0, 0, 8);
    checkOutput("nop exec t0 en", e0_en, 5'b00000);
    checkOutput("nop exec t1 en", e1_en, 5'b00000);

    // Reset in the middle of a stalled STA write.
    applyStimulus(4'h1, 1'b0, 1'b1);
    repeat (5) nextCycle();
    mem_bus.MEM_ACK = 1'b0;
    #1;
    checkOutput("abort state", st_vec, ST_ET1);
    checkOutput("abort write req", {mem_bus.MEM_REQ, mem_bus.MEM_WE}, 2'b11);
    repeat (2) nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("abort strobes in reset", {mem_bus.MEM_REQ, mem_bus.MEM_WE}, 2'b00);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("abort returns fetch t0", st_vec, ST_FT0);
    checkOutput("abort en_ma", en_ma, 1'b1);

    // Bus timeout on the fetch read.
    applyStimulus(4'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("timeout req state", st_vec, ST_FT1);
    checkOutput("timeout read req", {mem_bus.MEM_REQ, mem_bus.MEM_WE}, 2'b10);
    repeat (3) nextCycle();
    checkOutput("timeout 3 waits halted", halted, 1'b0);
    checkOutput("timeout 3 waits req", mem_bus.MEM_REQ, 1'b1);
    nextCycle();
    checkOutput("timeout bus_err", bus_err, 1'b1);
    checkOutput("timeout halted", halted, 1'b1);
    checkOutput("timeout req dropped", mem_bus.MEM_REQ, 1'b0);
    checkOutput("timeout state held", st_vec, ST_FT1);
    mem_bus.MEM_ACK = 1'b1;
    activity = 0;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      if (en_vec != 5'b00000 || mem_bus.MEM_REQ || st_vec != ST_FT1) activity++;
    end
    checkOutput("timeout frozen", activity, 0);
    resetPulse();
    checkOutput("timeout reset state", st_vec, ST_FT0);
    checkOutput("timeout reset status", {halted, bus_err}, 2'b00);

    // HLT freezes in EXECUTE T0.
    applyStimulus(4'hF, 1'b0, 1'b1);
    repeat (4) nextCycle();
    checkOutput("hlt exec t0 state", st_vec, ST_ET0);
    checkOutput("hlt not yet halted", halted, 1'b0);
    nextCycle();
    checkOutput("hlt halted", halted, 1'b1);
    checkOutput("hlt state", st_vec, ST_ET0);
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (en_vec != 5'b00000 || mem_bus.MEM_REQ || st_vec != ST_ET0) activity++;
    end
    checkOutput("hlt frozen", activity, 0);
    checkOutput("hlt no bus_err", bus_err, 1'b0);

    // Opcode decodes are combinational and valid while halted.
    for (int i = 0; i < 7; i++) begin
      ir_out = dec_ops[i];
      #1;
      checkOutput($sformatf("decode op %0h", dec_ops[i]), dec_vec, dec_exp[i]);
    end

    resetPulse();
    checkOutput("hlt reset state", st_vec, ST_FT0);
    checkOutput("hlt reset halted", halted, 1'b0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dunc16_ctrl.md
Name: dunc16_ctrl

Overview:
Control sequencer for the dunc16 16-bit accumulator datapath (PC, MA, MD, AC, IR).
- Generates the one-hot T0-T3 timing states, the FETCH/EXECUTE phase flags, register load enables, mux selects and memory strobes.
- Stretches T-states on memory wait, detects bus timeouts and halts on HLT.
- Sits beside the datapath in dunc16, replacing hand-wired schematic timing logic.

Parameters:
WAIT_LIMIT, 255, max consecutive stall cycles on one memory access before bus error.
WAIT_W, 8, stall counter width; must satisfy 2**WAIT_W > WAIT_LIMIT.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
IR_OUT  in  4  opcode from datapath IR
AZ  in  1  AC == 0
AN  in  1  AC[15] (negative)
MEM_ACK  in  1  memory completes current access this cycle
T0,T1,T2,T3  out  1 each  one-hot timing state
FETCH, EXECUTE  out  1 each  phase flags, exactly one high
EN_PC, EN_MA, EN_MD, EN_AC, EN_IR  out  1 each  register load enables
PC_SEL  out  1  0 = PC+1, 1 = MD[11:0] (jump target)
MA_SEL  out  1  0 = PC, 1 = MD[11:0] (operand address)
MD_SEL  out  1  0 = memory read data, 1 = AC
AC_SEL  out  1  0 = MD, 1 = AC+MD
MEM_REQ, MEM_WE  out  1 each  access request; WE=1 marks a write
I_LDA, I_STA, I_ADD, I_JMP, I_BAN, I_HLT  out  1 each  opcode decodes of IR_OUT
HALTED, BUS_ERR  out  1 each  sticky status

Behaviour:
- State = {phase, tstate}. Reset value: FETCH, T0. HALTED=0, BUS_ERR=0, stall count=0.
- While RESET=1, all EN_*, MEM_REQ and MEM_WE are forced to 0.
- Opcodes (IR_OUT): 0 LDA, 1 STA, 2 ADD, 3 JMP, 4 BAN, F HLT. All others are NOP: no enables in EXECUTE.
- I_* are pure combinational decodes of IR_OUT, valid in every phase.

FETCH:
- T0: EN_MA, MA_SEL=0.
- T1: MEM_REQ=1, MEM_WE=0. On MEM_ACK: EN_MD (MD_SEL=0), EN_PC (PC_SEL=0).
- T2: EN_IR; EN_MA with MA_SEL=1.
- T3: no enables. Next state is EXECUTE T0.

EXECUTE:
- T0:
  - LDA/ADD: MEM_REQ=1, WE=0; on MEM_ACK, EN_MD with MD_SEL=0.
  - STA: EN_MD with MD_SEL=1.
  - JMP: EN_PC with PC_SEL=1.
  - BAN: EN_PC with PC_SEL=1 only if AN=1.
  - HLT: set HALTED.
- T1:
  - LDA: EN_AC, AC_SEL=0.
  - ADD: EN_AC, AC_SEL=1.
  - STA: MEM_REQ=1, MEM_WE=1; hold until MEM_ACK.
- T2, T3: no enables. T3 goes to FETCH T0.

Timing and stall:
- Zero-wait instruction (MEM_ACK high in the request cycle) = 8 clocks.
- Stall: while MEM_REQ=1 and MEM_ACK=0, the T-state holds, enables gated by ACK stay 0, and the stall counter increments. Counter clears on ACK and on any T-state advance.
- If the counter reaches WAIT_LIMIT with no ACK, set BUS_ERR and HALTED, and drop MEM_REQ the next cycle.
- An ACK arriving in the same cycle the limit is reached wins: the access completes and no error is raised.

Halt:
- When HALTED=1, the state freezes, all EN_*/MEM_REQ are 0, and only RESET exits.
- The HLT instruction freezes in EXECUTE T0 with T0=1 and EXECUTE=1.

Reset and other rules:
- RESET mid-stall or mid-instruction aborts immediately: FETCH T0 on the next edge, no partial write enable after the reset edge.
- MEM_ACK outside MEM_REQ is ignored.
- AZ is reserved for a future BAZ opcode and is unused now.

Decomposition:
- Shared package dunc16_pkg: opcode localparams (OP_LDA..OP_HLT), phase and T-state encodings, select-value constants (SEL_PC, SEL_MD, AC_SUM, ...).
- One sub-module, dunc16_tgen: T-state/phase register with hold input, stall counter and timeout flag.
- dunc16_ctrl holds the decode and enable logic.

Test Plan:
- Reset: hold RESET for 2 clocks, then release -> T0=1, FETCH=1, all EN_*=0 during reset; first clock after release gives EN_MA=1, MA_SEL=0.
- LDA, zero-wait (IR=0, MEM_ACK tied 1) -> exactly 8 clocks per instruction; EN_AC with AC_SEL=0 at EXECUTE T1; EN_PC exactly once, in FETCH T1.
- STA with MEM_ACK delayed 3 cycles (IR=1) -> EXECUTE T1 held 4 clocks with MEM_REQ=1 and MEM_WE=1; instruction takes 11 clocks; EN_MD with MD_SEL=1 at EXECUTE T0.
- BAN: AN=1 -> EN_PC=1 with PC_SEL=1 in EXECUTE T0; AN=0 -> EN_PC=0. JMP (IR=3) -> EN_PC=1 regardless of AN.
- Timeout: WAIT_LIMIT=4, MEM_ACK stuck 0 in FETCH T1 -> BUS_ERR=1 and HALTED=1 after 4 stall cycles; MEM_REQ=0 the following cycle; state frozen until RESET.
- HLT (IR=F) -> HALTED=1 after EXECUTE T0, no enables for 20 clocks; RESET pulse returns to FETCH T0 with HALTED=0.
